// File: rtl/uart_tx_denetleyici.sv
// uart_tx_denetleyici: front-end for the UART transmitter.
// Two requesters share one TX FIFO through a round-robin arbiter.
// A two-state sequencer hands each byte to the transmitter and holds it
// stable for the whole frame. This block also owns tx_en and the baud
// divisor, and it changes the divisor only between frames.
module uart_tx_denetleyici #(
  parameter int          FIFO_DERINLIK       = 8,
  parameter logic [15:0] VARSAYILAN_BAUD_DIV = 16'd868
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             istek0_gecerli_i,
  input  logic [7:0]                       istek0_veri_i,
  output logic                             istek0_hazir_o,
  input  logic                             istek1_gecerli_i,
  input  logic [7:0]                       istek1_veri_i,
  output logic                             istek1_hazir_o,
  input  logic                             ayar_yaz_i,
  input  logic                             ayar_tx_en_i,
  input  logic [15:0]                      ayar_baud_div_i,
  output logic                             tx_en_o,
  output logic [15:0]                      baud_div_o,
  output logic                             veri_gecerli_o,
  output logic [7:0]                       veri_o,
  input  logic                             consume_i,
  input  logic                             verici_hazir_i,
  output logic [$clog2(FIFO_DERINLIK):0]   fifo_doluluk_o,
  output logic                             mesgul_o
);

  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int DW = AW + 1;

  typedef enum logic {
    BOSTA      = 1'b0,
    GONDERIYOR = 1'b1
  } durum_t;

  durum_t          r_durum;
  durum_t          w_durum_sonraki;

  logic [7:0]      r_fifo [FIFO_DERINLIK];
  logic [AW-1:0]   r_yaz_ptr;
  logic [AW-1:0]   r_oku_ptr;
  logic [DW-1:0]   r_doluluk;

  logic            r_oncelik;
  logic [7:0]      r_tutulan;
  logic            r_tx_en;
  logic [15:0]     r_baud;
  logic [15:0]     r_bekleyen_baud;
  logic            r_bekleyen;

  logic            w_dolu;
  logic            w_bos;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_push_veri;
  logic [7:0]      w_bas;
  logic            w_veri_gecerli;
  logic [7:0]      w_veri;

  assign w_dolu      = (r_doluluk == DW'(FIFO_DERINLIK));
  assign w_bos       = (r_doluluk == '0);
  assign w_bas       = r_fifo[r_oku_ptr];
  assign w_push      = w_grant0 | w_grant1;
  assign w_push_veri = w_grant0 ? istek0_veri_i : istek1_veri_i;

  // Round-robin arbiter: at most one grant per cycle, none while full (no bypass on a same-cycle pop)
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!w_dolu) begin
      if (istek0_gecerli_i && istek1_gecerli_i) begin
        if (r_oncelik) w_grant1 = 1'b1;
        else           w_grant0 = 1'b1;
      end else if (istek0_gecerli_i) begin
        w_grant0 = 1'b1;
      end else if (istek1_gecerli_i) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // After a grant, priority passes to the requester that lost (or was idle)
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_oncelik <= 1'b0;
    end else if (w_grant0) begin
      r_oncelik <= 1'b1;
    end else if (w_grant1) begin
      r_oncelik <= 1'b0;
    end
  end

  // FIFO storage: contents need no reset because occupancy and the empty mux guard every read
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_yaz_ptr] <= w_push_veri;
    end
  end

  // FIFO pointers and occupancy; the pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_doluluk <= '0;
    end else begin
      if (w_push) r_yaz_ptr <= r_yaz_ptr + 1'b1;
      if (w_pop)  r_oku_ptr <= r_oku_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_doluluk <= r_doluluk + 1'b1;
        2'b01:   r_doluluk <= r_doluluk - 1'b1;
        default: r_doluluk <= r_doluluk;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_durum_sonraki;
    end
  end

  // Sequencer next state and transmitter-facing outputs; a pending baud change blocks new frames
  always_comb begin
    w_durum_sonraki = r_durum;
    w_veri_gecerli  = 1'b0;
    w_veri          = 8'h00;
    w_pop           = 1'b0;
    case (r_durum)
      BOSTA: begin
        w_veri_gecerli = !w_bos && !r_bekleyen;
        if (!w_bos) w_veri = w_bas;
        if (consume_i && w_veri_gecerli) begin
          w_pop           = 1'b1;
          w_durum_sonraki = GONDERIYOR;
        end
      end
      GONDERIYOR: begin
        w_veri = r_tutulan;
        if (verici_hazir_i) w_durum_sonraki = BOSTA;
      end
      default: w_durum_sonraki = BOSTA;
    endcase
  end

  // Capture the byte at frame start so veri_o stays fixed while the transmitter shifts it out
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tutulan <= 8'h00;
    end else if (w_pop) begin
      r_tutulan <= w_bas;
    end
  end

  // Configuration: tx_en takes effect at once, the divisor waits for an idle cycle (last write wins)
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_en         <= 1'b0;
      r_baud          <= VARSAYILAN_BAUD_DIV;
      r_bekleyen_baud <= VARSAYILAN_BAUD_DIV;
      r_bekleyen      <= 1'b0;
    end else if (ayar_yaz_i) begin
      r_tx_en         <= ayar_tx_en_i;
      r_bekleyen_baud <= ayar_baud_div_i;
      r_bekleyen      <= 1'b1;
    end else if (r_bekleyen && (r_durum == BOSTA)) begin
      r_baud     <= r_bekleyen_baud;
      r_bekleyen <= 1'b0;
    end
  end

  assign istek0_hazir_o = w_grant0;
  assign istek1_hazir_o = w_grant1;
  assign tx_en_o        = r_tx_en;
  assign baud_div_o     = r_baud;
  assign veri_gecerli_o = w_veri_gecerli;
  assign veri_o         = w_veri;
  assign fifo_doluluk_o = r_doluluk;
  assign mesgul_o       = !w_bos || (r_durum == GONDERIYOR);

endmodule

// File: tb/tb_uart_tx_denetleyici.sv
// Testbench for uart_tx_denetleyici: a queue-based reference model predicts
// grants and transmitter-facing outputs each cycle, while a separate monitor
// pops accepted bytes from a scoreboard at every frame start and checks that
// the byte is held for the whole frame.
module tb_uart_tx_denetleyici;

  localparam int DEPTH = 8;
  localparam logic [15:0] DEF_BAUD = 16'd868;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        istek0_gecerli_i, istek1_gecerli_i;
  logic [7:0]  istek0_veri_i, istek1_veri_i;
  logic        istek0_hazir_o, istek1_hazir_o;
  logic        ayar_yaz_i, ayar_tx_en_i;
  logic [15:0] ayar_baud_div_i;
  logic        tx_en_o;
  logic [15:0] baud_div_o;
  logic        veri_gecerli_o;
  logic [7:0]  veri_o;
  logic        consume_i, verici_hazir_i;
  logic [3:0]  fifo_doluluk_o;
  logic        mesgul_o;

  uart_tx_denetleyici #(.FIFO_DERINLIK(DEPTH), .VARSAYILAN_BAUD_DIV(DEF_BAUD)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .istek0_gecerli_i(istek0_gecerli_i), .istek0_veri_i(istek0_veri_i), .istek0_hazir_o(istek0_hazir_o),
    .istek1_gecerli_i(istek1_gecerli_i), .istek1_veri_i(istek1_veri_i), .istek1_hazir_o(istek1_hazir_o),
    .ayar_yaz_i(ayar_yaz_i), .ayar_tx_en_i(ayar_tx_en_i), .ayar_baud_div_i(ayar_baud_div_i),
    .tx_en_o(tx_en_o), .baud_div_o(baud_div_o),
    .veri_gecerli_o(veri_gecerli_o), .veri_o(veri_o),
    .consume_i(consume_i), .verici_hazir_i(verici_hazir_i),
    .fifo_doluluk_o(fifo_doluluk_o), .mesgul_o(mesgul_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [7:0]  sbq[$];
  bit          mBusy, mPrio, mTxEn, mPend;
  logic [7:0]  mHeld;
  logic [15:0] mBaud, mPendVal;

  // Stimulus knobs
  bit          want0, want1;
  logic [7:0]  dat0, dat1;
  int          srcMode;
  int          cnt0, cnt1;
  bit          txAuto, forceConsume;
  int          frameLen;
  int          txCnt;
  bit          cfgWr, cfgTxEn;
  logic [15:0] cfgBaud;

  bit          eG0, eG1, eVg;
  logic [7:0]  eVeri;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    sbq.delete();
    mBusy = 0; mPrio = 0; mTxEn = 0; mPend = 0;
    mHeld = 8'h00; mBaud = DEF_BAUD; mPendVal = DEF_BAUD;
    want0 = 0; want1 = 0; txCnt = 0; forceConsume = 0; cfgWr = 0;
  endtask

  // One clock cycle: drive inputs, predict and compare outputs, then advance the model
  task automatic applyStimulus();
    bit busyPre;
    @(negedge clk_i);
    istek0_gecerli_i = want0;
    istek0_veri_i    = want0 ? dat0 : 8'h00;
    istek1_gecerli_i = want1;
    istek1_veri_i    = want1 ? dat1 : 8'h00;
    ayar_yaz_i       = cfgWr;
    ayar_tx_en_i     = cfgTxEn;
    ayar_baud_div_i  = cfgBaud;
    cfgWr            = 0;

    eVg   = !mBusy && (mq.size() > 0) && !mPend;
    eVeri = mBusy ? mHeld : ((mq.size() > 0) ? mq[0] : 8'h00);
    eG0 = 0; eG1 = 0;
    if (mq.size() < DEPTH) begin
      if (want0 && want1) begin
        if (mPrio) eG1 = 1; else eG0 = 1;
      end else if (want0) eG0 = 1;
      else if (want1) eG1 = 1;
    end

    consume_i      = 1'b0;
    verici_hazir_i = 1'b0;
    if (txCnt > 0) begin
      if (txCnt == 1) verici_hazir_i = 1'b1;
    end else if (forceConsume) begin
      consume_i    = eVg;
      forceConsume = 0;
    end else if (txAuto && mTxEn && eVg && ($urandom_range(0, 2) != 0)) begin
      consume_i = 1'b1;
    end else if (!mBusy && ($urandom_range(0, 15) == 0)) begin
      verici_hazir_i = 1'b1;
    end

    #1;
    checkOutput("hazir0", istek0_hazir_o, eG0);
    checkOutput("hazir1", istek1_hazir_o, eG1);
    checkOutput("veri_gecerli", veri_gecerli_o, eVg);
    checkOutput("veri", veri_o, eVeri);
    checkOutput("doluluk", fifo_doluluk_o, mq.size());
    checkOutput("mesgul", mesgul_o, (mq.size() != 0) || mBusy);
    checkOutput("tx_en", tx_en_o, mTxEn);
    checkOutput("baud", baud_div_o, mBaud);

    @(posedge clk_i);
    busyPre = mBusy;
    if (consume_i && eVg) begin
      mHeld = mq.pop_front();
      mBusy = 1;
    end else if (mBusy && verici_hazir_i) begin
      mBusy = 0;
    end
    if (eG0) begin
      mq.push_back(dat0); sbq.push_back(dat0); mPrio = 1;
    end else if (eG1) begin
      mq.push_back(dat1); sbq.push_back(dat1); mPrio = 0;
    end
    if (ayar_yaz_i) begin
      mTxEn = ayar_tx_en_i; mPendVal = ayar_baud_div_i; mPend = 1;
    end else if (mPend && !busyPre) begin
      mBaud = mPendVal; mPend = 0;
    end
    if (consume_i) txCnt = (frameLen > 0) ? frameLen : $urandom_range(1, 5);
    else if (txCnt > 0) txCnt--;

    if (eG0) begin
      if (srcMode == 1) begin cnt0++; dat0 = 8'hA0 + 8'(cnt0); end
      else want0 = 0;
    end
    if (eG1) begin
      if (srcMode == 1) begin cnt1++; dat1 = 8'hB0 + 8'(cnt1); end
      else want1 = 0;
    end
    if (srcMode == 2) begin
      if (!want0 && !eG0 && ($urandom_range(0, 2) == 0)) begin want0 = 1; dat0 = 8'($urandom); end
      if (!want1 && !eG1 && ($urandom_range(0, 2) == 0)) begin want1 = 1; dat1 = 8'($urandom); end
    end
  endtask

  task automatic pushByte(input int which, input logic [7:0] d);
    int n = 0;
    if (which == 0) begin want0 = 1; dat0 = d; end
    else            begin want1 = 1; dat1 = d; end
    while (((which == 0) ? want0 : want1) && n < 50) begin
      applyStimulus();
      n++;
    end
    if ((which == 0) ? want0 : want1) begin
      total++; bad++;
      $display("[TB] FAIL push_timeout: got=pending want=accepted");
      want0 = 0; want1 = 0;
    end
  endtask

  task automatic writeCfg(input bit en, input logic [15:0] b);
    cfgWr = 1; cfgTxEn = en; cfgBaud = b;
    applyStimulus();
  endtask

  task automatic drainAll(input int limit);
    int n = 0;
    while ((mq.size() > 0 || mBusy || want0 || want1) && n < limit) begin
      applyStimulus();
      n++;
    end
    if (mq.size() > 0 || mBusy || want0 || want1) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got=%0d queued want=0", mq.size());
    end
  endtask

  task automatic waitBusy(input int limit);
    int n = 0;
    while (!mBusy && n < limit) begin
      applyStimulus();
      n++;
    end
    if (!mBusy) begin
      total++; bad++;
      $display("[TB] FAIL busy_timeout: got=idle want=frame");
    end
  endtask

  // Monitor: pops the scoreboard on each frame start and checks the byte stays put during the frame
  initial begin
    bit         inFrame = 0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk_i);
      #2;
      if (rstn_i !== 1'b1) begin
        inFrame = 0;
      end else if (inFrame) begin
        checkOutput("frame_hold", veri_o, held);
        if (verici_hazir_i) inFrame = 0;
      end else if (consume_i) begin
        checkOutput("consume_ok", veri_gecerli_o, 1);
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL frame_byte: got=%0h want=none (scoreboard empty)", veri_o);
        end else begin
          held = sbq.pop_front();
          checkOutput("frame_byte", veri_o, held);
        end
        inFrame = 1;
      end
    end
  end

  initial begin
    rstn_i = 0;
    istek0_gecerli_i = 0; istek1_gecerli_i = 0;
    istek0_veri_i = 0; istek1_veri_i = 0;
    ayar_yaz_i = 0; ayar_tx_en_i = 0; ayar_baud_div_i = 0;
    consume_i = 0; verici_hazir_i = 0;
    srcMode = 0; cnt0 = 0; cnt1 = 0; txAuto = 0; frameLen = 0;
    cfgTxEn = 0; cfgBaud = DEF_BAUD; dat0 = 0; dat1 = 0;
    modelReset();

    // Reset values
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_baud", baud_div_o, 16'd868);
    checkOutput("rst_tx_en", tx_en_o, 0);
    checkOutput("rst_vg", veri_gecerli_o, 0);
    checkOutput("rst_doluluk", fifo_doluluk_o, 0);
    checkOutput("rst_mesgul", mesgul_o, 0);
    @(negedge clk_i);
    #3 rstn_i = 1;

    // Both requesters streaming: expect A0,B0,A1,B1,...
    srcMode = 1; cnt0 = 0; cnt1 = 0; dat0 = 8'hA0; dat1 = 8'hB0; want0 = 1; want1 = 1;
    repeat (6) applyStimulus();
    #1 checkOutput("stream_doluluk", fifo_doluluk_o, 6);
    srcMode = 0;
    repeat (2) applyStimulus();
    txAuto = 1; frameLen = 0;
    writeCfg(1, DEF_BAUD);
    drainAll(300);

    // Held byte during a frame while a new byte changes the FIFO head
    frameLen = 10;
    pushByte(0, 8'h55);
    waitBusy(40);
    pushByte(0, 8'h33);
    #1 checkOutput("hold_55", veri_o, 8'h55);
    drainAll(100);

    // Full FIFO, then a consume and a valid request in the same cycle
    txAuto = 0;
    writeCfg(0, DEF_BAUD);
    for (int i = 0; i < DEPTH; i++) pushByte(i % 2, 8'hC0 + 8'(i));
    #1 checkOutput("full_doluluk", fifo_doluluk_o, DEPTH);
    want0 = 1; dat0 = 8'hD0; want1 = 1; dat1 = 8'hE0;
    repeat (2) applyStimulus();
    writeCfg(1, DEF_BAUD);
    for (int i = 0; i < 10 && mPend; i++) applyStimulus();
    frameLen = 3;
    forceConsume = 1;
    applyStimulus();
    #1 checkOutput("full_pop_doluluk", fifo_doluluk_o, DEPTH - 1);
    applyStimulus();
    #1 checkOutput("refill_doluluk", fifo_doluluk_o, DEPTH);
    txAuto = 1;
    drainAll(300);

    // Baud change mid-frame with bytes queued
    frameLen = 8;
    pushByte(0, 8'h61);
    waitBusy(40);
    pushByte(1, 8'h62);
    pushByte(0, 8'h63);
    writeCfg(1, 16'd434);
    for (int i = 0; i < 20 && mBusy; i++) applyStimulus();
    #1;
    checkOutput("baud_before_apply", baud_div_o, 16'd868);
    checkOutput("vg_masked", veri_gecerli_o, 0);
    applyStimulus();
    #1 checkOutput("baud_after_apply", baud_div_o, 16'd434);
    drainAll(200);

    // Asynchronous reset mid-frame with three bytes queued
    frameLen = 10;
    pushByte(0, 8'h11);
    pushByte(1, 8'h22);
    pushByte(0, 8'h33);
    pushByte(1, 8'h44);
    for (int i = 0; i < 20 && !(mBusy && mq.size() == 3); i++) applyStimulus();
    #1 checkOutput("pre_reset_doluluk", fifo_doluluk_o, 3);
    #2;
    rstn_i = 0;
    istek0_gecerli_i = 0; istek1_gecerli_i = 0;
    consume_i = 0; verici_hazir_i = 0; ayar_yaz_i = 0;
    modelReset();
    #1;
    checkOutput("arst_baud", baud_div_o, 16'd868);
    checkOutput("arst_tx_en", tx_en_o, 0);
    checkOutput("arst_vg", veri_gecerli_o, 0);
    checkOutput("arst_veri", veri_o, 0);
    checkOutput("arst_doluluk", fifo_doluluk_o, 0);
    checkOutput("arst_mesgul", mesgul_o, 0);
    checkOutput("arst_hazir0", istek0_hazir_o, 0);
    checkOutput("arst_hazir1", istek1_hazir_o, 0);
    repeat (2) @(negedge clk_i);
    #3 rstn_i = 1;
    #1 checkOutput("post_reset_doluluk", fifo_doluluk_o, 0);

    // Randomized traffic with occasional configuration writes
    writeCfg(1, DEF_BAUD);
    srcMode = 2; frameLen = 0; txAuto = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfgWr = 1;
        cfgTxEn = ($urandom_range(0, 7) != 0);
        cfgBaud = 16'($urandom_range(1, 65535));
      end
      applyStimulus();
    end
    srcMode = 0;
    writeCfg(1, DEF_BAUD);
    drainAll(600);
    repeat (2) applyStimulus();
    checkOutput("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
